// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Multi-cycle MIPS control unit. A Moore FSM steps each instruction
//            through FETCH / DECODE / EXECUTE / MEM / WB and stalls on a
//            memory req/ack handshake. Decodes ADD SUB AND OR SLT (R-type)
//            plus ADDI LHI LOI LW SW BEQ.
// Ports    : clk, rst (async, active-high)
//            OPCODE, FUNCT  - instruction fields, sampled in DECODE only
//            ZERO           - ALU zero flag, sampled in BRANCH only
//            MEM_ACK        - memory completed the current request
//            MEM_REQ, I_OR_D, MEM_WRITE       - memory request side
//            PC_WRITE, PC_SRC, IR_WRITE       - PC / IR update strobes
//            REG_DST, REG_WRITE, MEM2REG      - register-file write control
//            EX_TOP, ALU_SRC, ALU_OP          - ALU operand / function
//            STATE          - current FSM state (debug)
// Config   : define ILLEGAL_TRAP_EN to lock unsupported ops in TRAP (4'hF)
//            until reset; otherwise unsupported ops are NOPs.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int ALU_OP_W = 4,
    parameter int MEM_TO_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          OPCODE,
    input  logic [5:0]          FUNCT,
    input  logic                ZERO,
    input  logic                MEM_ACK,
    output logic                MEM_REQ,
    output logic                PC_WRITE,
    output logic                PC_SRC,
    output logic                IR_WRITE,
    output logic                I_OR_D,
    output logic                REG_DST,
    output logic                REG_WRITE,
    output logic                EX_TOP,
    output logic                ALU_SRC,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                MEM_WRITE,
    output logic                MEM2REG,
    output logic [3:0]          STATE
);

    // State encoding
    localparam logic [3:0] c_ST_FETCH    = 4'h0;
    localparam logic [3:0] c_ST_DECODE   = 4'h1;
    localparam logic [3:0] c_ST_EXEC_R   = 4'h2;
    localparam logic [3:0] c_ST_EXEC_I   = 4'h3;
    localparam logic [3:0] c_ST_WB_ALU   = 4'h4;
    localparam logic [3:0] c_ST_MEM_ADDR = 4'h5;
    localparam logic [3:0] c_ST_MEM_RD   = 4'h6;
    localparam logic [3:0] c_ST_MEM_WR   = 4'h7;
    localparam logic [3:0] c_ST_WB_MEM   = 4'h8;
    localparam logic [3:0] c_ST_BRANCH   = 4'h9;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] c_ST_TRAP     = 4'hF;
    localparam logic [3:0] c_ST_ILLEGAL  = c_ST_TRAP;
`else
    localparam logic [3:0] c_ST_ILLEGAL  = c_ST_FETCH;
`endif

    // Opcodes (LHI/LOI use the LUI/ORI slots of the MIPS opcode map)
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LHI   = 6'b001111;
    localparam logic [5:0] c_OP_LOI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;

    // R-type function fields
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    // ALU function codes (low 4 bits of ALU_OP)
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_LHI = 4'b1000;
    localparam logic [3:0] c_ALU_LOI = 4'b1001;

    localparam logic [MEM_TO_W-1:0] c_TO_ONE = MEM_TO_W'(1);
    localparam logic [MEM_TO_W-1:0] c_TO_MAX = {MEM_TO_W{1'b1}};

    function automatic logic f_funct_ok(input logic [5:0] fn);
        return (fn == c_FN_ADD) || (fn == c_FN_SUB) || (fn == c_FN_AND) ||
               (fn == c_FN_OR)  || (fn == c_FN_SLT);
    endfunction

    function automatic logic [3:0] f_alu_r(input logic [5:0] fn);
        case (fn)
            c_FN_ADD: return c_ALU_ADD;
            c_FN_SUB: return c_ALU_SUB;
            c_FN_AND: return c_ALU_AND;
            c_FN_OR:  return c_ALU_OR;
            c_FN_SLT: return c_ALU_SLT;
            default:  return c_ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] f_alu_i(input logic [5:0] op);
        case (op)
            c_OP_LHI: return c_ALU_LHI;
            c_OP_LOI: return c_ALU_LOI;
            default:  return c_ALU_ADD;
        endcase
    endfunction

    logic [3:0]          r_state;
    logic [3:0]          w_next_state;
    logic [5:0]          r_opcode;
    logic [5:0]          r_funct;
    logic [MEM_TO_W-1:0] r_to_cnt;
    logic                w_to_sat;
    logic                w_in_mem;
    logic                w_next_mem;
    logic [5:0]          w_op_eff;
    logic [5:0]          w_fn_eff;

    logic                r_mem_req, w_mem_req;
    logic                r_pc_write, w_pc_write;
    logic                r_pc_src, w_pc_src;
    logic                r_ir_write, w_ir_write;
    logic                r_i_or_d, w_i_or_d;
    logic                r_reg_dst, w_reg_dst;
    logic                r_reg_write, w_reg_write;
    logic                r_ex_top, w_ex_top;
    logic                r_alu_src, w_alu_src;
    logic [ALU_OP_W-1:0] r_alu_op, w_alu_op;
    logic                r_mem_write, w_mem_write;
    logic                r_mem2reg, w_mem2reg;

    assign w_in_mem   = (r_state == c_ST_MEM_RD) || (r_state == c_ST_MEM_WR);
    assign w_next_mem = (w_next_state == c_ST_MEM_RD) || (w_next_state == c_ST_MEM_WR);
    assign w_to_sat   = (r_to_cnt == c_TO_MAX);

    // Outputs for the state entered from DECODE must come from the live IR
    // fields; later states use the copy latched in DECODE.
    assign w_op_eff = (r_state == c_ST_DECODE) ? OPCODE : r_opcode;
    assign w_fn_eff = (r_state == c_ST_DECODE) ? FUNCT  : r_funct;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_FETCH: begin
                if (MEM_ACK) w_next_state = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                if (OPCODE == c_OP_RTYPE)
                    w_next_state = f_funct_ok(FUNCT) ? c_ST_EXEC_R : c_ST_ILLEGAL;
                else if ((OPCODE == c_OP_ADDI) || (OPCODE == c_OP_LHI) || (OPCODE == c_OP_LOI))
                    w_next_state = c_ST_EXEC_I;
                else if ((OPCODE == c_OP_LW) || (OPCODE == c_OP_SW))
                    w_next_state = c_ST_MEM_ADDR;
                else if (OPCODE == c_OP_BEQ)
                    w_next_state = c_ST_BRANCH;
                else
                    w_next_state = c_ST_ILLEGAL;
            end
            c_ST_EXEC_R,
            c_ST_EXEC_I:   w_next_state = c_ST_WB_ALU;
            c_ST_WB_ALU:   w_next_state = c_ST_FETCH;
            c_ST_MEM_ADDR: w_next_state = (r_opcode == c_OP_LW) ? c_ST_MEM_RD : c_ST_MEM_WR;
            c_ST_MEM_RD: begin
                // ACK on the last counted cycle still completes the load
                if (MEM_ACK)       w_next_state = c_ST_WB_MEM;
                else if (w_to_sat) w_next_state = c_ST_FETCH;
            end
            c_ST_MEM_WR: begin
                if (MEM_ACK || w_to_sat) w_next_state = c_ST_FETCH;
            end
            c_ST_WB_MEM:   w_next_state = c_ST_FETCH;
            c_ST_BRANCH:   w_next_state = c_ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            c_ST_TRAP:     w_next_state = c_ST_TRAP;
`endif
            default:       w_next_state = c_ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state; registered below
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_req   = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 1'b0;
        w_ir_write  = 1'b0;
        w_i_or_d    = 1'b0;
        w_reg_dst   = 1'b0;
        w_reg_write = 1'b0;
        w_ex_top    = 1'b0;
        w_alu_src   = 1'b0;
        w_alu_op    = '0;
        w_mem_write = 1'b0;
        w_mem2reg   = 1'b0;
        case (w_next_state)
            c_ST_FETCH: begin
                w_mem_req = 1'b1;
                // A taken branch commits its target during the first FETCH cycle
                if ((r_state == c_ST_BRANCH) && ZERO) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = 1'b1;
                end
            end
            c_ST_DECODE: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
            end
            c_ST_EXEC_R: begin
                w_reg_dst     = 1'b1;
                w_alu_op[3:0] = f_alu_r(w_fn_eff);
            end
            c_ST_EXEC_I: begin
                w_alu_src     = 1'b1;
                w_ex_top      = (w_op_eff == c_OP_ADDI);
                w_alu_op[3:0] = f_alu_i(w_op_eff);
            end
            c_ST_WB_ALU: begin
                // ALU controls are held so an unregistered result stays valid
                w_reg_write = 1'b1;
                w_mem2reg   = 1'b1;
                if (w_op_eff == c_OP_RTYPE) begin
                    w_reg_dst     = 1'b1;
                    w_alu_op[3:0] = f_alu_r(w_fn_eff);
                end else begin
                    w_alu_src     = 1'b1;
                    w_ex_top      = (w_op_eff == c_OP_ADDI);
                    w_alu_op[3:0] = f_alu_i(w_op_eff);
                end
            end
            c_ST_MEM_ADDR: begin
                w_alu_src     = 1'b1;
                w_ex_top      = 1'b1;
                w_alu_op[3:0] = c_ALU_ADD;
            end
            c_ST_MEM_RD,
            c_ST_MEM_WR: begin
                // Address computation held stable for the whole request
                w_alu_src     = 1'b1;
                w_ex_top      = 1'b1;
                w_alu_op[3:0] = c_ALU_ADD;
                w_mem_req     = 1'b1;
                w_i_or_d      = 1'b1;
                w_mem_write   = (w_next_state == c_ST_MEM_WR);
            end
            c_ST_WB_MEM: begin
                w_reg_write = 1'b1;
            end
            c_ST_BRANCH: begin
                w_alu_op[3:0] = c_ALU_SUB;
            end
            default: begin
                // TRAP and unused codes: every strobe low
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, IR field latch and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_FETCH;
            r_opcode    <= 6'd0;
            r_funct     <= 6'd0;
            r_mem_req   <= 1'b1;
            r_pc_write  <= 1'b0;
            r_pc_src    <= 1'b0;
            r_ir_write  <= 1'b0;
            r_i_or_d    <= 1'b0;
            r_reg_dst   <= 1'b0;
            r_reg_write <= 1'b0;
            r_ex_top    <= 1'b0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= '0;
            r_mem_write <= 1'b0;
            r_mem2reg   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            if (r_state == c_ST_DECODE) begin
                r_opcode <= OPCODE;
                r_funct  <= FUNCT;
            end
            r_mem_req   <= w_mem_req;
            r_pc_write  <= w_pc_write;
            r_pc_src    <= w_pc_src;
            r_ir_write  <= w_ir_write;
            r_i_or_d    <= w_i_or_d;
            r_reg_dst   <= w_reg_dst;
            r_reg_write <= w_reg_write;
            r_ex_top    <= w_ex_top;
            r_alu_src   <= w_alu_src;
            r_alu_op    <= w_alu_op;
            r_mem_write <= w_mem_write;
            r_mem2reg   <= w_mem2reg;
        end
    end

    // Memory timeout: counts cycles spent in MEM_RD/MEM_WR starting at 1,
    // so reaching all-ones means 2**MEM_TO_W-1 cycles without an ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_next_mem && !w_in_mem) begin
            r_to_cnt <= c_TO_ONE;
        end else if (w_in_mem && !w_to_sat) begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
        end
    end

    assign MEM_REQ   = r_mem_req;
    assign PC_WRITE  = r_pc_write;
    assign PC_SRC    = r_pc_src;
    assign IR_WRITE  = r_ir_write;
    assign I_OR_D    = r_i_or_d;
    assign REG_DST   = r_reg_dst;
    assign REG_WRITE = r_reg_write;
    assign EX_TOP    = r_ex_top;
    assign ALU_SRC   = r_alu_src;
    assign ALU_OP    = r_alu_op;
    assign MEM_WRITE = r_mem_write;
    assign MEM2REG   = r_mem2reg;
    assign STATE     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Purpose  : Self-checking bench for mips_multicycle_ctrl. Each instruction
//            is expanded into the per-cycle list of phases it must walk
//            through; every cycle's outputs are checked against the phase
//            table, plus hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    localparam int MEM_TO_W = 4;
    localparam int TO_CYC   = (1 << MEM_TO_W) - 1;

    localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3, P_WB_ALU = 4;
    localparam int P_MEM_ADDR = 5, P_MEM_RD = 6, P_MEM_WR = 7, P_WB_MEM = 8, P_BRANCH = 9;
    localparam int P_TRAP = 15;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LHI = 6'b001111;
    localparam logic [5:0] OP_LOI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_BAD = 6'b100111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ack;
    logic       mem_req, pc_write, pc_src, ir_write, i_or_d, reg_dst, reg_write;
    logic       ex_top, alu_src, mem_write, mem2reg;
    logic [3:0] alu_op, state;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.ALU_OP_W(4), .MEM_TO_W(MEM_TO_W)) dut (
        .clk(clk), .rst(rst), .OPCODE(opcode), .FUNCT(funct), .ZERO(zero),
        .MEM_ACK(mem_ack), .MEM_REQ(mem_req), .PC_WRITE(pc_write), .PC_SRC(pc_src),
        .IR_WRITE(ir_write), .I_OR_D(i_or_d), .REG_DST(reg_dst), .REG_WRITE(reg_write),
        .EX_TOP(ex_top), .ALU_SRC(alu_src), .ALU_OP(alu_op), .MEM_WRITE(mem_write),
        .MEM2REG(mem2reg), .STATE(state)
    );

    typedef struct packed {
        logic       mem_req, pc_write, pc_src, ir_write, i_or_d, reg_dst, reg_write;
        logic       ex_top, alu_src;
        logic [3:0] alu_op;
        logic       mem_write, mem2reg;
        logic [3:0] state;
    } vec_t;

    vec_t act;
    assign act = {mem_req, pc_write, pc_src, ir_write, i_or_d, reg_dst, reg_write,
                  ex_top, alu_src, alu_op, mem_write, mem2reg, state};

    int          checks = 0;
    int          failures = 0;
    vec_t        exp_q[$];
    string       lit_name[$];
    logic [31:0] lit_got[$];
    logic [31:0] lit_exp[$];
    vec_t        hist[$];
    int          cyc_n = 0;
    logic [5:0]  cur_op, cur_fn;
    bit          br_pend = 1'b0;
    int          n0, n1;
    vec_t        rv;
    vec_t        cmp_e;
    string       cmp_n;
    logic [31:0] cmp_g, cmp_x;

    // ---------------- instruction-level model ----------------
    function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD: return 4'b0010;
            FN_SUB: return 4'b0110;
            FN_AND: return 4'b0000;
            FN_OR:  return 4'b0001;
            FN_SLT: return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of_op(input logic [5:0] op);
        if (op == OP_LHI) return 4'b1000;
        if (op == OP_LOI) return 4'b1001;
        return 4'b0010;
    endfunction

    function automatic bit funct_ok(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    // Outputs that must be visible while the instruction sits in phase ph
    function automatic vec_t model(input int ph, input bit taken);
        vec_t v;
        v = '0;
        v.state = 4'(ph);
        case (ph)
            P_FETCH: begin v.mem_req = 1'b1; v.pc_write = taken; v.pc_src = taken; end
            P_DECODE: begin v.ir_write = 1'b1; v.pc_write = 1'b1; end
            P_EXEC_R: begin v.reg_dst = 1'b1; v.alu_op = alu_of_funct(cur_fn); end
            P_EXEC_I: begin
                v.alu_src = 1'b1; v.ex_top = (cur_op == OP_ADDI); v.alu_op = alu_of_op(cur_op);
            end
            P_WB_ALU: begin
                v.reg_write = 1'b1; v.mem2reg = 1'b1;
                if (cur_op == OP_R) begin
                    v.reg_dst = 1'b1; v.alu_op = alu_of_funct(cur_fn);
                end else begin
                    v.alu_src = 1'b1; v.ex_top = (cur_op == OP_ADDI); v.alu_op = alu_of_op(cur_op);
                end
            end
            P_MEM_ADDR, P_MEM_RD, P_MEM_WR: begin
                v.alu_op = 4'b0010; v.alu_src = 1'b1; v.ex_top = 1'b1;
                if (ph != P_MEM_ADDR) begin
                    v.mem_req = 1'b1; v.i_or_d = 1'b1; v.mem_write = (ph == P_MEM_WR);
                end
            end
            P_WB_MEM: v.reg_write = 1'b1;
            P_BRANCH: v.alu_op = 4'b0110;
            default: ;
        endcase
        return v;
    endfunction

    // ---------------- single compare process ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            checks++;
            if (act !== cmp_e) begin
                failures++;
                $display("FAIL cycle_vec t=%0t got=%b expected=%b (state got=%0h expected=%0h)",
                         $time, act, cmp_e, act.state, cmp_e.state);
            end
        end
        while (lit_name.size() > 0) begin
            cmp_n = lit_name.pop_front();
            cmp_g = lit_got.pop_front();
            cmp_x = lit_exp.pop_front();
            checks++;
            if (cmp_g !== cmp_x) begin
                failures++;
                $display("FAIL %s got=%0h expected=%0h", cmp_n, cmp_g, cmp_x);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        lit_name.push_back(nm);
        lit_got.push_back(got);
        lit_exp.push_back(exp);
    endtask

    // One clock cycle spent in phase ph; called just after a rising edge
    task automatic cyc(input int ph, input logic ack, input logic z);
        bit taken;
        taken = (ph == P_FETCH) && br_pend;
        if (ph == P_FETCH) br_pend = 1'b0;
        mem_ack = ack;
        zero    = z;
        opcode  = (ph == P_DECODE) ? cur_op : 6'($urandom);
        funct   = (ph == P_DECODE) ? cur_fn : 6'($urandom);
        hist.push_back(act);
        exp_q.push_back(model(ph, taken));
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expand one instruction into its phase sequence. mwait<0: never ACK.
    // ACK is driven high in non-waiting phases to show it is ignored there.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fwait, input int mwait, input logic z);
        int mph;
        cur_op = op;
        cur_fn = fn;
        for (int i = 0; i < fwait; i++) cyc(P_FETCH, 1'b0, 1'($urandom));
        cyc(P_FETCH, 1'b1, 1'($urandom));
        cyc(P_DECODE, 1'b1, 1'($urandom));
        if (op == OP_R && funct_ok(fn)) begin
            cyc(P_EXEC_R, 1'b1, 1'($urandom));
            cyc(P_WB_ALU, 1'b1, 1'($urandom));
        end else if (op == OP_ADDI || op == OP_LHI || op == OP_LOI) begin
            cyc(P_EXEC_I, 1'b1, 1'($urandom));
            cyc(P_WB_ALU, 1'b1, 1'($urandom));
        end else if (op == OP_LW || op == OP_SW) begin
            cyc(P_MEM_ADDR, 1'b1, 1'($urandom));
            mph = (op == OP_LW) ? P_MEM_RD : P_MEM_WR;
            if (mwait < 0) begin
                for (int i = 0; i < TO_CYC; i++) cyc(mph, 1'b0, 1'($urandom));
            end else begin
                for (int i = 0; i < mwait; i++) cyc(mph, 1'b0, 1'($urandom));
                cyc(mph, 1'b1, 1'($urandom));
                if (op == OP_LW) cyc(P_WB_MEM, 1'b1, 1'($urandom));
            end
        end else if (op == OP_BEQ) begin
            cyc(P_BRANCH, 1'b1, z);
            br_pend = z;
        end else begin
`ifdef ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++) cyc(P_TRAP, 1'($urandom), 1'($urandom));
            lit("trap_state", 32'(state), 32'hF);
            reset_pulse();
`endif
        end
    endtask

    initial begin
        rv = '0;
        rv.mem_req = 1'b1;
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset_vec", 32'(act), 32'(rv));
        rst = 1'b0;

        // ADD with ACK on the first FETCH cycle: four cycles, writes rd
        n0 = cyc_n;
        run_instr(OP_R, FN_ADD, 0, 0, 1'b0);
        lit("add_cycles", 32'(cyc_n - n0), 32'd4);
        lit("add_wb_reg_write", 32'(hist[n0+3].reg_write), 32'd1);
        lit("add_wb_reg_dst", 32'(hist[n0+3].reg_dst), 32'd1);
        lit("add_wb_alu_op", 32'(hist[n0+3].alu_op), 32'b0010);

        // Remaining ALU operations, with varying fetch latency
        run_instr(OP_R, FN_SUB, 2, 0, 1'b0);
        run_instr(OP_R, FN_AND, 1, 0, 1'b0);
        run_instr(OP_R, FN_OR, 0, 0, 1'b0);
        run_instr(OP_R, FN_SLT, 3, 0, 1'b0);
        run_instr(OP_ADDI, 6'h15, 0, 0, 1'b0);
        run_instr(OP_LHI, 6'h2a, 1, 0, 1'b0);
        run_instr(OP_LOI, 6'h01, 0, 0, 1'b0);

        // LW with ACK three cycles late
        n0 = cyc_n;
        run_instr(OP_LW, 6'h00, 0, 3, 1'b0);
        for (int k = 3; k < 6; k++)
            lit("lw_req_held", 32'({hist[n0+k].mem_req, hist[n0+k].i_or_d}), 32'b11);
        lit("lw_wb_reg_write", 32'(hist[n0+7].reg_write), 32'd1);
        lit("lw_wb_mem2reg", 32'(hist[n0+7].mem2reg), 32'd0);

        // SW acknowledged immediately
        run_instr(OP_SW, 6'h00, 1, 0, 1'b0);

        // BEQ taken, then not taken
        run_instr(OP_BEQ, 6'h00, 0, 0, 1'b1);
        n1 = cyc_n;
        run_instr(OP_ADDI, 6'h00, 1, 0, 1'b0);
        lit("beq_taken_pc", 32'({hist[n1].pc_write, hist[n1].pc_src}), 32'b11);
        run_instr(OP_BEQ, 6'h00, 0, 0, 1'b0);
        n1 = cyc_n;
        run_instr(OP_R, FN_ADD, 1, 0, 1'b0);
        lit("beq_not_taken_pc", 32'({hist[n1].pc_write, hist[n1].pc_src}), 32'b00);

        // SW that is never acknowledged: timeout back to FETCH
        n0 = cyc_n;
        run_instr(OP_SW, 6'h00, 0, -1, 1'b0);
        lit("sw_to_cycles", 32'(cyc_n - n0), 32'(3 + TO_CYC));
        lit("sw_to_last_mem_write", 32'(hist[n0+17].mem_write), 32'd1);
        lit("sw_to_state", 32'(state), 32'd0);
        lit("sw_to_strobes", 32'({mem_write, reg_write, i_or_d}), 32'b000);

        // LW timeout must not write the register file
        run_instr(OP_LW, 6'h00, 0, -1, 1'b0);
        run_instr(OP_R, FN_OR, 0, 0, 1'b0);

`ifndef ILLEGAL_TRAP_EN
        // Unsupported opcode / funct: NOP straight back to FETCH
        n0 = cyc_n;
        run_instr(OP_BAD, 6'h00, 0, 0, 1'b0);
        lit("illegal_cycles", 32'(cyc_n - n0), 32'd2);
        lit("illegal_state", 32'(state), 32'd0);
        run_instr(OP_R, FN_BAD, 0, 0, 1'b0);
`else
        run_instr(OP_BAD, 6'h00, 0, 0, 1'b0);
`endif

        // Reset asserted in the middle of a store
        cur_op = OP_SW;
        cur_fn = 6'h00;
        cyc(P_FETCH, 1'b1, 1'b0);
        cyc(P_DECODE, 1'b0, 1'b0);
        cyc(P_MEM_ADDR, 1'b0, 1'b0);
        cyc(P_MEM_WR, 1'b0, 1'b0);
        cyc(P_MEM_WR, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        lit("rst_async_vec", 32'(act), 32'(rv));
        @(posedge clk);
        #1;
        lit("rst_hold_vec", 32'(act), 32'(rv));
        rst = 1'b0;
        run_instr(OP_R, FN_SUB, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
